// File: rtl/demux16bit4way_stream_pkg.sv
// Shared constants for the 4-way 16-bit stream demultiplexer.
package demux16bit4way_stream_pkg;
  localparam int SEL_W     = 2;
  localparam int N_CH      = 4;
  localparam int CH_A      = 0;
  localparam int CH_B      = 1;
  localparam int CH_C      = 2;
  localparam int CH_D      = 3;
  localparam int DEF_WIDTH = 16;
  localparam int DEF_CNT_W = 8;
endpackage

// File: rtl/demux_slot.sv
// One demux output channel: single-entry holding register plus delivered-word counter.
// slot_rdy tells the top whether a word aimed at this channel could be taken this cycle.
module demux_slot #(
  parameter int WIDTH = 16,
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             load,
  input  logic [WIDTH-1:0] in_data,
  input  logic             out_ready,
  input  logic             cnt_clr,
  output logic             out_valid,
  output logic [WIDTH-1:0] out_data,
  output logic [CNT_W-1:0] cnt,
  output logic             slot_rdy
);
  logic             full_q, full_d;
  logic [WIDTH-1:0] data_q, data_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             drain;

  assign drain = full_q && out_ready;

  always_comb begin
    full_d = full_q;
    data_d = data_q;
    cnt_d  = cnt_q;
    // A load wins over a drain so a same-cycle drain+refill keeps the slot full.
    if (load) begin
      full_d = 1'b1;
      data_d = in_data;
    end else if (drain) begin
      full_d = 1'b0;
    end
    if (cnt_clr) begin
      cnt_d = '0;
    end else if (drain) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      full_q <= 1'b0;
      data_q <= '0;
      cnt_q  <= '0;
    end else begin
      full_q <= full_d;
      data_q <= data_d;
      cnt_q  <= cnt_d;
    end
  end

  assign out_valid = full_q;
  assign out_data  = data_q;
  assign cnt       = cnt_q;
  assign slot_rdy  = !full_q || out_ready;
endmodule

// File: rtl/demux16bit4way_stream.sv
// Registered 4-way stream demux: one valid/ready input routed to channel a..d by in_sel.
// Only the selected channel's slot gates in_ready, so a stalled consumer blocks only itself.
module demux16bit4way_stream
  import demux16bit4way_stream_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH,
  parameter int CNT_W = DEF_CNT_W
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] in_data,
  input  logic [SEL_W-1:0] in_sel,
  input  logic             in_valid,
  output logic             in_ready,
  output logic [WIDTH-1:0] out_a_data,
  output logic [WIDTH-1:0] out_b_data,
  output logic [WIDTH-1:0] out_c_data,
  output logic [WIDTH-1:0] out_d_data,
  output logic             out_a_valid,
  output logic             out_b_valid,
  output logic             out_c_valid,
  output logic             out_d_valid,
  input  logic             out_a_ready,
  input  logic             out_b_ready,
  input  logic             out_c_ready,
  input  logic             out_d_ready,
  input  logic             cnt_clr,
  output logic [CNT_W-1:0] cnt_a,
  output logic [CNT_W-1:0] cnt_b,
  output logic [CNT_W-1:0] cnt_c,
  output logic [CNT_W-1:0] cnt_d,
  output logic             busy
);
  logic [N_CH-1:0]  load;
  logic [N_CH-1:0]  slot_rdy;
  logic [N_CH-1:0]  o_rdy;
  logic [N_CH-1:0]  o_vld;
  logic [WIDTH-1:0] o_dat [N_CH];
  logic [CNT_W-1:0] o_cnt [N_CH];

  assign o_rdy    = {out_d_ready, out_c_ready, out_b_ready, out_a_ready};
  assign in_ready = slot_rdy[in_sel];

  always_comb begin
    load = '0;
    if (in_valid && in_ready) begin
      load[in_sel] = 1'b1;
    end
  end

  for (genvar k = 0; k < N_CH; k++) begin : g_slot
    demux_slot #(
      .WIDTH(WIDTH),
      .CNT_W(CNT_W)
    ) u_slot (
      .clk      (clk),
      .rst_n    (rst_n),
      .load     (load[k]),
      .in_data  (in_data),
      .out_ready(o_rdy[k]),
      .cnt_clr  (cnt_clr),
      .out_valid(o_vld[k]),
      .out_data (o_dat[k]),
      .cnt      (o_cnt[k]),
      .slot_rdy (slot_rdy[k])
    );
  end

  assign out_a_data  = o_dat[CH_A];
  assign out_b_data  = o_dat[CH_B];
  assign out_c_data  = o_dat[CH_C];
  assign out_d_data  = o_dat[CH_D];
  assign out_a_valid = o_vld[CH_A];
  assign out_b_valid = o_vld[CH_B];
  assign out_c_valid = o_vld[CH_C];
  assign out_d_valid = o_vld[CH_D];
  assign cnt_a       = o_cnt[CH_A];
  assign cnt_b       = o_cnt[CH_B];
  assign cnt_c       = o_cnt[CH_C];
  assign cnt_d       = o_cnt[CH_D];
  assign busy        = |o_vld;
endmodule

// File: tb/tb_demux16bit4way_stream.sv
// Bench for demux16bit4way_stream: behavioural channel model checked every negedge,
// directed scenarios with literal expectations, then randomized traffic.
module tb_demux16bit4way_stream;
  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [15:0] in_data = '0;
  logic [1:0]  in_sel = '0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic        cnt_clr = 1'b0;
  logic        busy;
  logic [15:0] od [4];
  logic        ov [4];
  logic        orr [4];
  logic [7:0]  cn [4];

  int n_vec = 0;
  int n_err = 0;
  bit chk_en = 0;

  // Reference model: each channel is a one-word mailbox with a delivery tally.
  bit          m_full [4] = '{0, 0, 0, 0};
  logic [15:0] m_word [4] = '{16'h0, 16'h0, 16'h0, 16'h0};
  int          m_cnt  [4] = '{0, 0, 0, 0};

  demux16bit4way_stream dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .in_data    (in_data),
    .in_sel     (in_sel),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .out_a_data (od[0]),
    .out_b_data (od[1]),
    .out_c_data (od[2]),
    .out_d_data (od[3]),
    .out_a_valid(ov[0]),
    .out_b_valid(ov[1]),
    .out_c_valid(ov[2]),
    .out_d_valid(ov[3]),
    .out_a_ready(orr[0]),
    .out_b_ready(orr[1]),
    .out_c_ready(orr[2]),
    .out_d_ready(orr[3]),
    .cnt_clr    (cnt_clr),
    .cnt_a      (cn[0]),
    .cnt_b      (cn[1]),
    .cnt_c      (cn[2]),
    .cnt_d      (cn[3]),
    .busy       (busy)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h, expected %h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic bit model_ready();
    return !m_full[in_sel] || orr[in_sel];
  endfunction

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int k = 0; k < 4; k++) begin
        m_full[k] = 0;
        m_word[k] = '0;
        m_cnt[k]  = 0;
      end
    end else begin
      bit acc;
      acc = in_valid && model_ready();
      for (int k = 0; k < 4; k++) begin
        bit delivered;
        delivered = m_full[k] && orr[k];
        if (delivered) m_full[k] = 0;
        if (cnt_clr) m_cnt[k] = 0;
        else if (delivered) m_cnt[k] = (m_cnt[k] + 1) % 256;
      end
      if (acc) begin
        m_full[in_sel] = 1;
        m_word[in_sel] = in_data;
      end
    end
  end

  always @(negedge clk) begin
    if (chk_en) begin
      bit any;
      any = 0;
      for (int k = 0; k < 4; k++) begin
        chk($sformatf("valid%0d", k), {31'b0, ov[k]}, {31'b0, m_full[k]});
        if (m_full[k]) chk($sformatf("data%0d", k), {16'b0, od[k]}, {16'b0, m_word[k]});
        chk($sformatf("cnt%0d", k), {24'b0, cn[k]}, m_cnt[k]);
        any = any | m_full[k];
      end
      chk("busy", {31'b0, busy}, {31'b0, any});
      chk("in_ready", {31'b0, in_ready}, {31'b0, model_ready()});
    end
  end

  task automatic drive(input bit v, input int sel, input logic [15:0] d);
    in_valid = v;
    in_sel   = 2'(sel);
    in_data  = d;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    for (int k = 0; k < 4; k++) orr[k] = 1'b1;
    #12;
    chk("rst_busy", {31'b0, busy}, 32'd0);
    chk("rst_data_a", {16'b0, od[0]}, 32'd0);
    chk("rst_cnt_d", {24'b0, cn[3]}, 32'd0);
    rst_n = 1'b1;
    tick();
    chk_en = 1;

    // 1: one word per channel, all consumers ready
    for (int i = 0; i < 4; i++) begin
      drive(1, i, 16'h1111 * 16'(i + 1));
      #1 chk("t1_in_ready", {31'b0, in_ready}, 32'd1);
      tick();
      chk("t1_valid", {31'b0, ov[i]}, 32'd1);
      chk("t1_data", {16'b0, od[i]}, 32'h1111 * (i + 1));
    end
    drive(0, 0, '0);
    tick();
    for (int i = 0; i < 4; i++) chk("t1_cnt", {24'b0, cn[i]}, 32'd1);

    // 2: stall b, second word blocked until drain
    orr[1] = 1'b0;
    drive(1, 1, 16'hAAAA);
    tick();
    drive(1, 1, 16'hBBBB);
    #1 chk("t2_blocked", {31'b0, in_ready}, 32'd0);
    tick();
    chk("t2_hold", {16'b0, od[1]}, 32'hAAAA);
    orr[1] = 1'b1;
    #1 chk("t2_ready", {31'b0, in_ready}, 32'd1);
    tick();
    drive(0, 0, '0);
    chk("t2_refill", {16'b0, od[1]}, 32'hBBBB);
    chk("t2_cnt_b", {24'b0, cn[1]}, 32'd2);
    tick();
    chk("t2_cnt_b2", {24'b0, cn[1]}, 32'd3);

    // 3: b stalled and full, c still reachable
    orr[1] = 1'b0;
    drive(1, 1, 16'h1234);
    tick();
    drive(1, 2, 16'hCCCC);
    #1 chk("t3_ready_c", {31'b0, in_ready}, 32'd1);
    tick();
    drive(0, 0, '0);
    chk("t3_c_data", {16'b0, od[2]}, 32'hCCCC);
    chk("t3_b_held", {31'b0, ov[1]}, 32'd1);
    chk("t3_cnt_b", {24'b0, cn[1]}, 32'd3);
    orr[1] = 1'b1;
    tick();
    tick();

    // 4: counter wrap on d, then clear colliding with a handshake
    cnt_clr = 1'b1;
    tick();
    cnt_clr = 1'b0;
    for (int i = 0; i < 256; i++) begin
      drive(1, 3, 16'(i));
      tick();
    end
    chk("t4_cnt_255", {24'b0, cn[3]}, 32'd255);
    drive(0, 0, '0);
    tick();
    chk("t4_wrap", {24'b0, cn[3]}, 32'd0);
    drive(1, 3, 16'h0001);
    tick();
    drive(1, 3, 16'h0002);
    tick();
    chk("t4_cnt1", {24'b0, cn[3]}, 32'd1);
    drive(0, 0, '0);
    cnt_clr = 1'b1;
    tick();
    cnt_clr = 1'b0;
    chk("t4_clr_wins", {24'b0, cn[3]}, 32'd0);

    // 5: asynchronous reset between edges discards a held word
    orr[0] = 1'b0;
    drive(1, 0, 16'hFACE);
    tick();
    drive(0, 0, '0);
    chk("t5_loaded", {16'b0, od[0]}, 32'hFACE);
    #1 rst_n = 1'b0;
    #1;
    chk("t5_async_drop", {31'b0, ov[0]}, 32'd0);
    chk("t5_busy", {31'b0, busy}, 32'd0);
    #1 rst_n = 1'b1;
    tick();
    tick();
    chk("t5_no_valid", {31'b0, ov[0]}, 32'd0);
    chk("t5_cnt_a", {24'b0, cn[0]}, 32'd0);

    // 6: edge data with in_sel moving while in_valid is low
    orr[0] = 1'b0;
    orr[1] = 1'b0;
    drive(0, 1, 16'hFFFF); tick();
    drive(1, 0, 16'h0000); tick();
    drive(0, 0, 16'h1234); tick();
    drive(1, 1, 16'hFFFF); tick();
    drive(0, 2, 16'h5555); tick();
    chk("t6_a", {16'b0, od[0]}, 32'h0000);
    chk("t6_a_vld", {31'b0, ov[0]}, 32'd1);
    chk("t6_b", {16'b0, od[1]}, 32'hFFFF);
    chk("t6_c_idle", {31'b0, ov[2]}, 32'd0);
    orr[0] = 1'b1;
    orr[1] = 1'b1;
    tick();

    // Randomized traffic
    for (int i = 0; i < 3000; i++) begin
      drive($urandom_range(0, 1) == 1, int'($urandom_range(0, 3)), 16'($urandom));
      for (int k = 0; k < 4; k++) orr[k] = $urandom_range(0, 3) != 0;
      cnt_clr = $urandom_range(0, 63) == 0;
      tick();
    end
    drive(0, 0, '0);
    cnt_clr = 1'b0;
    tick();
    chk_en = 0;

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
